// File: rtl/router_pkg.sv
// Shared router definitions: port indices, port count and the one-hot port vector type.
// Used by the output arbiter, output controller and input buffers.
// No logic, so no latency or backpressure behaviour of its own.
package router_pkg;

    localparam int N_PORTS = 5;

    localparam int PORT_PE = 0;
    localparam int PORT_S  = 1;
    localparam int PORT_N  = 2;
    localparam int PORT_E  = 3;
    localparam int PORT_W  = 4;

    typedef logic [N_PORTS-1:0] port_vec_t;

endpackage

// File: rtl/rr_pick.sv
// Circular priority encoder: first set request at or after ptr wins (ptr 5..7 reads as 0).
// Latency: purely combinational.
// Backpressure: none; the caller gates the result.
module rr_pick
    import router_pkg::*;
(
    input  port_vec_t   req,
    input  logic [2:0]  ptr,
    output port_vec_t   gnt,
    output logic [2:0]  idx
);

    logic [2:0] start;
    logic [3:0] pos;
    logic       found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        start = (ptr > 3'd4) ? 3'd0 : ptr;
        for (int k = 0; k < N_PORTS; k++) begin
            pos = {1'b0, start} + 4'(k);
            if (pos >= 4'(N_PORTS)) begin
                pos = pos - 4'(N_PORTS);
            end
            if (!found && req[pos[2:0]]) begin
                found          = 1'b1;
                gnt[pos[2:0]]  = 1'b1;
                idx            = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Per-output-port round-robin arbiter, independent fairness for even/odd VCs; OUT_PORT_ARBITER_GRANT_CNT_EN adds grant counters.
// Latency: grant is combinational from req/polarity/out_ready; pointer and mask update at the next edge.
// Backpressure: out_ready low forces grant to zero and freezes both pointers.
module out_port_arbiter
    import router_pkg::*;
#(
    parameter int N_REQ = 5,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   polarity,
    input  logic [N_REQ-1:0]       req_even,
    input  logic [N_REQ-1:0]       req_odd,
    input  logic                   out_ready,
    output logic [N_REQ-1:0]       grant,
    output logic                   grant_valid
`ifdef OUT_PORT_ARBITER_GRANT_CNT_EN
    ,
    output logic [N_REQ*CNT_W-1:0] grant_cnt
`endif
);

    if (N_REQ != N_PORTS || CNT_W < 1) begin : g_bad_cfg
        $error("out_port_arbiter: N_REQ must be 5 and CNT_W at least 1");
    end

    logic [2:0] ptr_even;
    logic [2:0] ptr_odd;
    port_vec_t  last_grant;
    logic       last_pol;

    port_vec_t  mask_eff;
    port_vec_t  req_act;
    port_vec_t  pick_gnt;
    logic [2:0] pick_idx;
    logic [2:0] ptr_next;

    // Masking the previous winner covers the clear round-trip when polarity fails to toggle.
    assign mask_eff = (polarity == last_pol) ? last_grant : '0;
    assign req_act  = (polarity ? req_odd : req_even) & ~mask_eff;

    rr_pick u_pick (
        .req (req_act),
        .ptr (polarity ? ptr_odd : ptr_even),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign grant       = (reset || !out_ready) ? '0 : pick_gnt;
    assign grant_valid = |grant;
    assign ptr_next    = (pick_idx >= 3'd4) ? 3'd0 : pick_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_even   <= '0;
            ptr_odd    <= '0;
            last_grant <= '0;
            last_pol   <= 1'b0;
        end else begin
            if (grant_valid) begin
                if (polarity) ptr_odd  <= ptr_next;
                else          ptr_even <= ptr_next;
            end
            last_grant <= grant;
            last_pol   <= polarity;
        end
    end

`ifdef OUT_PORT_ARBITER_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt [N_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else if (grant[i] && (cnt[i] != {CNT_W{1'b1}})) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_out_port_arbiter.sv
// Bench for out_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_out_port_arbiter;

`ifdef OUT_PORT_ARBITER_GRANT_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       polarity;
    logic [4:0] req_even;
    logic [4:0] req_odd;
    logic       out_ready;
    logic [4:0] grant;
    logic       grant_valid;
`ifdef OUT_PORT_ARBITER_GRANT_CNT_EN
    logic [5*CW-1:0] grant_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    // Reference state: one round-robin pointer per polarity, plus the previous grant/polarity.
    int         m_ptr [2];
    logic [4:0] m_last;
    logic       m_lpol;

    out_port_arbiter #(.N_REQ(5), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .polarity    (polarity),
        .req_even    (req_even),
        .req_odd     (req_odd),
        .out_ready   (out_ready),
        .grant       (grant),
        .grant_valid (grant_valid)
`ifdef OUT_PORT_ARBITER_GRANT_CNT_EN
        ,
        .grant_cnt   (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] model_grant();
        logic [4:0] r;
        int p, i;
        if (reset || !out_ready) return 5'b0;
        r = polarity ? req_odd : req_even;
        if (polarity == m_lpol) r = r & ~m_last;
        p = polarity ? 1 : 0;
        for (int d = 0; d < 5; d++) begin
            i = (m_ptr[p] + d) % 5;
            if (r[i]) return 5'b00001 << i;
        end
        return 5'b0;
    endfunction

    task automatic model_step(input logic [4:0] g);
        if (reset) begin
            m_ptr[0] = 0; m_ptr[1] = 0; m_last = '0; m_lpol = 1'b0;
        end else begin
            for (int i = 0; i < 5; i++)
                if (g[i]) m_ptr[polarity ? 1 : 0] = (i + 1) % 5;
            m_last = g;
            m_lpol = polarity;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; out_ready = 1'b1; polarity = 1'b0; req_even = '0; req_odd = '0;
        @(posedge clk); model_step(5'b0); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        reset = 1'b1; out_ready = 1'b1; req_even = 5'b11111; req_odd = 5'b11111;
        for (int c = 0; c < 2; c++) begin
            polarity = c[0];
            @(negedge clk);
            exp = model_grant();
            vectors++;
            if (grant !== 5'b0 || exp !== 5'b0) begin
                errors++; $display("FAIL reset_grant cyc %0d got=%b exp=00000", c, grant);
            end
            vectors++;
            if (grant_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid cyc %0d got=%b exp=0", c, grant_valid);
            end
            @(posedge clk); model_step(exp); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_rotate();
        logic [4:0] exp_even [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        logic [4:0] exp;
        do_reset();
        req_even = 5'b11111; req_odd = '0;
        for (int c = 0; c < 12; c++) begin
            polarity = c[0];
            @(negedge clk);
            exp = polarity ? 5'b0 : exp_even[c/2];
            vectors++;
            if (grant !== exp || model_grant() !== exp) begin
                errors++; $display("FAIL rotate cyc %0d got=%b exp=%b", c, grant, exp);
            end
            @(posedge clk); model_step(exp); #1;
        end
    endtask

    task automatic test_two_vc();
        logic [4:0] exp_e [3] = '{5'b00100, 5'b10000, 5'b00100};
        logic [4:0] exp_o [3] = '{5'b00001, 5'b00010, 5'b00001};
        logic [4:0] exp;
        do_reset();
        req_even = 5'b10100; req_odd = 5'b00011;
        for (int c = 0; c < 6; c++) begin
            polarity = c[0];
            @(negedge clk);
            exp = polarity ? exp_o[c/2] : exp_e[c/2];
            vectors++;
            if (grant !== exp) begin
                errors++; $display("FAIL two_vc cyc %0d pol=%0d got=%b exp=%b", c, polarity, grant, exp);
            end
            @(posedge clk); model_step(exp); #1;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_even = 5'b11111; req_odd = '0; polarity = 1'b0;
        @(negedge clk);
        vectors++;
        if (grant !== 5'b00001) begin
            errors++; $display("FAIL bp_first got=%b exp=00001", grant);
        end
        @(posedge clk); model_step(grant); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (grant !== 5'b0 || grant_valid !== 1'b0) begin
                errors++; $display("FAIL bp_stall cyc %0d got=%b valid=%b exp=00000", c, grant, grant_valid);
            end
            @(posedge clk); model_step(5'b0); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (grant !== 5'b00010) begin
            errors++; $display("FAIL bp_resume got=%b exp=00010", grant);
        end
        @(posedge clk); model_step(5'b00010); #1;
    endtask

    task automatic test_mask();
        logic [4:0] exp [3] = '{5'b00001, 5'b00000, 5'b00001};
        do_reset();
        polarity = 1'b0; req_even = 5'b00001; req_odd = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (grant !== exp[c]) begin
                errors++; $display("FAIL mask cyc %0d got=%b exp=%b", c, grant, exp[c]);
            end
            @(posedge clk); model_step(exp[c]); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp [2] = '{5'b00001, 5'b00010};
        do_reset();
        polarity = 1'b0; req_even = 5'b11111; req_odd = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (grant !== exp[c]) begin
                errors++; $display("FAIL rmid_pre cyc %0d got=%b exp=%b", c, grant, exp[c]);
            end
            @(posedge clk); model_step(exp[c]); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (grant !== 5'b0) begin
            errors++; $display("FAIL rmid_during got=%b exp=00000", grant);
        end
        @(posedge clk); model_step(5'b0); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (grant !== 5'b00001) begin
            errors++; $display("FAIL rmid_after got=%b exp=00001", grant);
        end
        @(posedge clk); model_step(5'b00001); #1;
    endtask

    task automatic test_random();
        logic [4:0] exp;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_even  = 5'($urandom);
            req_odd   = 5'($urandom);
            polarity  = ($urandom_range(0, 3) != 0) ? ~polarity : polarity;
            out_ready = ($urandom_range(0, 5) != 0);
            reset     = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            exp = model_grant();
            vectors++;
            if (grant !== exp || grant_valid !== (|exp)) begin
                errors++;
                $display("FAIL random cyc %0d pol=%0d re=%b ro=%b rdy=%0d got=%b/%b exp=%b",
                         c, polarity, req_even, req_odd, out_ready, grant, grant_valid, exp);
            end
            @(posedge clk); model_step(exp); #1;
        end
        reset = 1'b0; out_ready = 1'b1;
    endtask

`ifdef OUT_PORT_ARBITER_GRANT_CNT_EN
    task automatic test_counters();
        logic [5*CW-1:0] exp_cnt;
        do_reset();
        req_even = 5'b00001; req_odd = 5'b00001;
        for (int c = 0; c < 5; c++) begin
            polarity = c[0];
            @(negedge clk);
            @(posedge clk); model_step(grant); #1;
        end
        req_even = '0; req_odd = '0;
        @(negedge clk);
        exp_cnt = '0;
        exp_cnt[1:0] = 2'b11;
        vectors++;
        if (grant_cnt !== exp_cnt) begin
            errors++; $display("FAIL cnt_sat got=%h exp=%h", grant_cnt, exp_cnt);
        end
        do_reset();
        @(negedge clk);
        vectors++;
        if (grant_cnt !== '0) begin
            errors++; $display("FAIL cnt_reset got=%h exp=0", grant_cnt);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; polarity = 1'b0; req_even = '0; req_odd = '0; out_ready = 1'b1;
        m_ptr[0] = 0; m_ptr[1] = 0; m_last = '0; m_lpol = 1'b0;
        #1;
        test_reset();
        test_rotate();
        test_two_vc();
        test_backpressure();
        test_mask();
        test_reset_mid();
        test_random();
`ifdef OUT_PORT_ARBITER_GRANT_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
